counter_sweep_ctrl: RTL
=======================

// Module: counter_sweep_ctrl
// PURPOSE
//  Sequencer for the team's up/down/load counter: accepts a sweep command (start, end, pass count),
//  loads the counter, steps it toward end, optionally ping-pongs between endpoints, pulses done.
//  Sits beside the counter; owns its load/enable/up_down inputs and monitors its count output.
// PARAMETERS
//  WIDTH     4   counter/endpoint width in bits
//  PASS_W    4   width of the pass-count field
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       controller can accept (IDLE only)
//  cmd_start    in   WIDTH   first endpoint, loaded into counter
//  cmd_end      in   WIDTH   second endpoint
//  cmd_passes   in   PASS_W  number of sweeps; 0 treated as 1
//  abort        in   1       synchronous cancel of active command
//  ctr_value    in   WIDTH   counter output being monitored
//  ctr_load     out  1       load strobe to counter
//  ctr_din      out  WIDTH   load value to counter
//  ctr_up_down  out  1       1=count up, 0=count down
//  ctr_enable   out  1       counter step enable
//  busy         out  1       command in progress (state != IDLE)
//  done         out  1       one-cycle pulse at normal completion
//  passes_left  out  PASS_W  remaining passes incl. current
// BEHAVIOUR
//  - Reset: state IDLE; ctr_load=0, ctr_din=0, ctr_up_down=1, ctr_enable=0, busy=0, done=0,
//    passes_left=0; cmd_ready=1 after reset. rst wins over all other inputs.
//  - FSM IDLE->LOAD->RUN->(TURN->RUN)*->DONE->IDLE.
//  - IDLE: cmd_ready=1 (combinational on state). cmd_valid&&cmd_ready at edge T latches start/end/passes
//    and dir = (end >= start) (unsigned compare); state LOAD at T+1.
//  - LOAD (1 cycle): ctr_load=1, ctr_din=start, ctr_up_down=dir. Counter holds start from T+2.
//  - RUN: ctr_enable = (state==RUN) && (ctr_value != target), combinational -> no overshoot.
//    target = end on odd passes, start on even passes. ctr_value==target in RUN ends the pass.
//  - Pass end: passes_left>1 -> TURN (1 cycle, enable=0): passes_left--, swap target, invert ctr_up_down,
//    then RUN. passes_left==1 -> DONE.
//  - DONE (1 cycle): done=1, busy=1; next cycle IDLE, passes_left=0.
//  - Latency, 1 pass, N=|end-start| steps: accept T, LOAD T+1, RUN T+2..T+2+N, done at T+3+N, cmd_ready T+4+N.
//  - start==end: each pass ends in its first RUN cycle; no enable pulses; TURN still inserted between passes.
//  - No wrap-around: direction always chosen toward target; counter never crosses 0 or 2^WIDTH-1.
//  - ctr_load, ctr_din, ctr_up_down, passes_left, done registered; ctr_enable, cmd_ready, busy combinational.
//  - abort in LOAD/RUN/TURN/DONE: next cycle IDLE, no done pulse, enable/load low; counter keeps its value.
//    abort in IDLE ignored; abort concurrent with cmd_valid in IDLE: command accepted.
//  - cmd_valid outside IDLE ignored (cmd_ready=0); no queuing.
//  - ctr_value changing unexpectedly (external load) is tolerated: controller stops when it equals target.
// CONFIGURATION
//  - CTR_PAUSE_EN defined: adds input `pause` (1 bit). In RUN, pause=1 forces ctr_enable=0 and freezes FSM;
//    pass-end detection suppressed while paused; abort still honoured. Pause ignored in other states.
//  - CTR_PAUSE_EN undefined: no pause port; behaviour exactly as above.
// TESTING
//  - Reset: assert rst 2 cycles mid-RUN -> all outputs at reset values next cycle, cmd_ready=1.
//  - Up sweep start=2,end=9,passes=1 -> ctr_load pulse with din=2, 7 enable cycles up_down=1, done at T+10.
//  - Ping-pong start=12,end=3,passes=3 -> 12->3 down, TURN, 3->12 up, TURN, 12->3 down; done once; 27 enables.
//  - Degenerate start=end=5,passes=0 -> no enable pulses, done at T+3, passes_left 1 then 0.
//  - Abort at 4th RUN cycle of 0->15 sweep -> IDLE next cycle, no done, counter frozen at 4.
//  - CTR_PAUSE_EN: pause 3 cycles during 0->6 sweep -> enable low while paused, done delayed by 3 cycles.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
// Sweep sequencer for the up/down/load counter. Accepts a command (start,
// end, pass count), loads the counter with start, then steps it toward the
// current target. It ping-pongs between the endpoints for the requested
// number of passes and pulses done at normal completion.
// Optional feature macro: CTR_PAUSE_EN adds a 'pause' input that freezes
// the sweep while in RUN.
module counter_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_start,
    input  logic [WIDTH-1:0]  cmd_end,
    input  logic [PASS_W-1:0] cmd_passes,
    input  logic              abort,
`ifdef CTR_PAUSE_EN
    input  logic              pause,
`endif
    input  logic [WIDTH-1:0]  ctr_value,
    output logic              ctr_load,
    output logic [WIDTH-1:0]  ctr_din,
    output logic              ctr_up_down,
    output logic              ctr_enable,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] passes_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_TURN,
        S_DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  start_q;
    logic [WIDTH-1:0]  end_q;
    logic              to_end_q;
    logic [WIDTH-1:0]  target;
    logic              at_target;
    logic              paused;

    // Current sweep target: odd passes head to end, even passes back to start
    always_comb begin
        target    = to_end_q ? end_q : start_q;
        at_target = (ctr_value == target);
    end

`ifdef CTR_PAUSE_EN
    // Pause only has an effect while sweeping
    always_comb begin
        paused = pause && (state == S_RUN);
    end
`else
    // Without the pause feature the sweep is never held
    always_comb begin
        paused = 1'b0;
    end
`endif

    // Combinational handshake and step enable; enable drops the same cycle the
    // counter reaches target so it never overshoots
    always_comb begin
        cmd_ready  = (state == S_IDLE);
        busy       = (state != S_IDLE);
        ctr_enable = (state == S_RUN) && !at_target && !paused;
    end

    // Sequencer state and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ctr_load    <= 1'b0;
            ctr_din     <= '0;
            ctr_up_down <= 1'b1;
            done        <= 1'b0;
            passes_left <= '0;
            start_q     <= '0;
            end_q       <= '0;
            to_end_q    <= 1'b1;
        end else begin
            ctr_load <= 1'b0;
            done     <= 1'b0;
            if ((state != S_IDLE) && abort) begin
                state       <= S_IDLE;
                passes_left <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            start_q     <= cmd_start;
                            end_q       <= cmd_end;
                            to_end_q    <= 1'b1;
                            ctr_din     <= cmd_start;
                            ctr_load    <= 1'b1;
                            ctr_up_down <= (cmd_end >= cmd_start);
                            passes_left <= (cmd_passes == '0) ? PASS_W'(1) : cmd_passes;
                            state       <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        if (!paused && at_target) begin
                            if (passes_left > PASS_W'(1)) begin
                                passes_left <= passes_left - PASS_W'(1);
                                to_end_q    <= !to_end_q;
                                ctr_up_down <= !ctr_up_down;
                                state       <= S_TURN;
                            end else begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    end
                    S_TURN: begin
                        state <= S_RUN;
                    end
                    S_DONE: begin
                        passes_left <= '0;
                        state       <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
